sprite_renderer_n: RTL
======================

SPRITE_RENDERER_N -- requirements
Module: sprite_renderer_n

Interface
REQ-001 Parameter WIDTH, default 16: sprite width in pixels; legal values 8, 16, 32.
REQ-002 Parameter HEIGHT, default 16: sprite height in lines; legal values 8, 16, 32.
REQ-003 Derived localparam BPL = WIDTH/8 (bytes per line); AW = log2(HEIGHT)+log2(BPL).
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 vstart  in  1  frame start; arms the renderer.
REQ-007 load  in  1  begin fetching the next sprite line.
REQ-008 hstart  in  1  begin drawing the fetched line.
REQ-009 hmirror, vmirror  in  1 each  horizontal / vertical mirror requests.
REQ-010 rom_addr  out  AW  registered ROM address = {row, byte_index}.
REQ-011 rom_bits  in  8  ROM data, combinational from rom_addr.
REQ-012 gfx  out  1  registered pixel output.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 done  out  1  one-cycle pulse after the last pixel of the last line.

Function
REQ-015 States: IDLE, WAIT_LOAD, SETUP, FETCH, WAIT_HSTART, DRAW.
REQ-016 IDLE: ycount<=0, gfx<=0; vstart -> WAIT_LOAD; all other inputs ignored.
REQ-017 WAIT_LOAD: xcount<=0, byte_index<=0, gfx<=0; on load latch hmirror/vmirror into line-mirror registers, -> SETUP.
REQ-018 SETUP: rom_addr<={vm ? HEIGHT-1-ycount : ycount, byte_index}; -> FETCH.
REQ-019 FETCH: line_buf[8*byte_index +: 8]<=rom_bits; if byte_index==BPL-1 -> WAIT_HSTART, else byte_index+1 and -> SETUP.
REQ-020 Fetch latency: exactly 2*BPL cycles from load acceptance to entry into WAIT_HSTART.
REQ-021 Pixel ordering: byte k bit j is pixel 8k+j; pixel 0 is leftmost.
REQ-022 WAIT_HSTART: hstart -> DRAW; hstart asserted during SETUP/FETCH is ignored, not queued.
REQ-023 DRAW: gfx<=line_buf[hm ? WIDTH-1-xcount : xcount], one pixel per cycle (see REQ-032), xcount+1.
REQ-024 End of line (last pixel): ycount+1; if ycount==HEIGHT-1 -> IDLE and done<=1 for one cycle, else -> WAIT_LOAD.
REQ-025 gfx returns to 0 on first cycle after DRAW; output pixel appears one cycle after its DRAW cycle.
REQ-026 Mirror inputs changing mid-line have no effect until next load acceptance.
REQ-027 vstart while busy is ignored; sprite in progress completes normally.
REQ-028 Counters sized to log2(WIDTH)/log2(HEIGHT) bits; wrap on terminal value, no overflow state.

Reset
REQ-029 Reset asserted at any time -> state IDLE, gfx=0, done=0, rom_addr=0, ycount=xcount=byte_index=0, line_buf=0, mirror registers=0, immediately and asynchronously.
REQ-030 Reset mid-line aborts the sprite; no done pulse is produced.

Configuration
REQ-031 Macro SPRITE_STRETCH_EN, when defined, compiles in 2x horizontal stretch.
REQ-032 With SPRITE_STRETCH_EN: each pixel held 2 cycles, DRAW lasts 2*WIDTH cycles; without: DRAW lasts WIDTH cycles.
REQ-033 Fetch timing, mirroring and ROM addressing identical in both builds.

Verification
REQ-034 WIDTH=16,HEIGHT=16, ROM row r = {8'hA5, r}; vstart, load, hstart per line -> 16 lines drawn, line 3 gfx sequence = bits of 16'hA503 LSB first, done pulses once.
REQ-035 Same ROM, vmirror=1 at load of line 0 -> rom_addr row field 15 then 14..., first line drawn = 16'hA50F.
REQ-036 hmirror=1 on line 0 -> gfx sequence is 16'hA500 MSB first; toggling hmirror during DRAW changes nothing.
REQ-037 WIDTH=32 -> 4 SETUP/FETCH pairs, rom_addr byte field 0..3, WAIT_HSTART entered 8 cycles after load; hstart pulsed 3 cycles after load ignored.
REQ-038 Reset asserted on line 7 pixel 5 -> gfx=0, busy=0 same cycle, no done; subsequent vstart redraws from line 0.
REQ-039 SPRITE_STRETCH_EN defined, WIDTH=8 -> DRAW lasts 16 cycles, each pixel value repeated twice.

Source files
------------

// File: rtl/sprite_renderer_n.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer_n
//  Purpose  : Line-by-line sprite renderer: fetches each sprite line from a
//             combinational ROM into a line buffer, then shifts it out as one
//             pixel per cycle with optional horizontal/vertical mirroring.
//             Define SPRITE_STRETCH_EN to hold every pixel for two cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_renderer_n #(
  parameter  int WIDTH  = 16,
  parameter  int HEIGHT = 16,
  localparam int AW     = $clog2(HEIGHT) + $clog2(WIDTH / 8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vstart,
  input  logic          load,
  input  logic          hstart,
  input  logic          hmirror,
  input  logic          vmirror,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_bits,
  output logic          gfx,
  output logic          busy,
  output logic          done
);

  localparam int BPL = WIDTH / 8;
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(BPL - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    SETUP       = 3'd2,
    FETCH       = 3'd3,
    WAIT_HSTART = 3'd4,
    DRAW        = 3'd5
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [YW-1:0]  ycount;
  logic [XW-1:0]  xcount;
  logic [BW-1:0]  byte_index;
  logic [WIDTH-1:0] line_buf;
  logic           hm;
  logic           vm;
  logic [YW-1:0]  row;
  logic [AW-1:0]  addr_next;
  logic           pixel;
  logic           x_adv;
  logic           line_end;

  // Sizes are powers of two, so N-1-count is simply the bitwise complement.
  assign row   = vm ? ~ycount : ycount;
  assign pixel = line_buf[hm ? ~xcount : xcount];
  assign busy  = (state != IDLE);

  generate
    if (BPL > 1) begin : g_addr_bytes
      assign addr_next = {row, byte_index};
    end else begin : g_addr_row
      assign addr_next = row;
    end
  endgenerate

`ifdef SPRITE_STRETCH_EN
  logic phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (state == DRAW) begin
      phase <= ~phase;
    end else begin
      phase <= 1'b0;
    end
  end

  assign x_adv    = phase;
  assign line_end = phase & (&xcount);
`else
  assign x_adv    = 1'b1;
  assign line_end = &xcount;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (vstart) state_nx = WAIT_LOAD;
      WAIT_LOAD:   if (load)   state_nx = SETUP;
      SETUP:       state_nx = FETCH;
      FETCH:       state_nx = (byte_index == BYTE_LAST) ? WAIT_HSTART : SETUP;
      WAIT_HSTART: if (hstart) state_nx = DRAW;
      DRAW: begin
        if (line_end) state_nx = (&ycount) ? IDLE : WAIT_LOAD;
      end
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ycount     <= '0;
      xcount     <= '0;
      byte_index <= '0;
      line_buf   <= '0;
      hm         <= 1'b0;
      vm         <= 1'b0;
      rom_addr   <= '0;
      gfx        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ycount <= '0;
          gfx    <= 1'b0;
        end
        WAIT_LOAD: begin
          xcount     <= '0;
          byte_index <= '0;
          gfx        <= 1'b0;
          // Mirror requests are sampled only here so mid-line changes are inert.
          if (load) begin
            hm <= hmirror;
            vm <= vmirror;
          end
        end
        SETUP: begin
          rom_addr <= addr_next;
        end
        FETCH: begin
          line_buf[{byte_index, 3'b000} +: 8] <= rom_bits;
          if (byte_index != BYTE_LAST) byte_index <= byte_index + 1'b1;
        end
        DRAW: begin
          gfx <= pixel;
          if (x_adv) xcount <= xcount + 1'b1;
          if (line_end) begin
            ycount <= ycount + 1'b1;
            if (&ycount) done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
